// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and RAS action codes for the branch target unit
package branch_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    JAL    = 2'b01,
    BRANCH = 2'b10,
    JALR   = 2'b11
  } br_op_t;

  localparam logic [1:0] RAS_ACT_NONE    = 2'd0;
  localparam logic [1:0] RAS_ACT_PUSH    = 2'd1;
  localparam logic [1:0] RAS_ACT_POP     = 2'd2;
  localparam logic [1:0] RAS_ACT_REPLACE = 2'd3;

  // Call/return hinting from the link-register usage of rd and rs1.
  function automatic logic [1:0] ras_action(input br_op_t op, input logic rd_link,
                                            input logic rs1_link);
    logic [1:0] act;
    act = RAS_ACT_NONE;
    case (op)
      JAL: begin
        if (rd_link) act = RAS_ACT_PUSH;
      end
      JALR: begin
        case ({rd_link, rs1_link})
          2'b10:   act = RAS_ACT_PUSH;
          2'b01:   act = RAS_ACT_POP;
          2'b11:   act = RAS_ACT_REPLACE;
          default: act = RAS_ACT_NONE;
        endcase
      end
      default: act = RAS_ACT_NONE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack that overwrites its oldest entry when full
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  localparam int PW       = $clog2(RAS_DEPTH),
  localparam int CW       = $clog2(RAS_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count
);

  localparam logic [CW-1:0] FULL    = CW'(RAS_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  // ptr is the next free slot; the newest entry sits just below it.
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;

  assign top_idx = ptr - PTR_ONE;
  assign top     = mem[top_idx];

  // Push/pop/replace; a push+pop pair on an empty stack degrades to a plain push.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr   <= '0;
      count <= '0;
      for (int k = 0; k < RAS_DEPTH; k++) mem[k] <= '0;
    end else if (push && pop && count != '0) begin
      mem[top_idx] <= data;
    end else if (push) begin
      mem[ptr] <= data;
      ptr      <= ptr + PTR_ONE;
      if (count != FULL) count <= count + CNT_ONE;
    end else if (pop && count != '0) begin
      ptr   <= top_idx;
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_target_unit.sv
// rtl/branch_target_unit.sv - registered JAL/BRANCH/JALR target generator with RAS prediction
module branch_target_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  parameter int ALIGN     = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  br_op_t          OP,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] I,
  input  logic [XLEN-1:0] J,
  input  logic [XLEN-1:0] B,
  input  logic            RD_LINK,
  input  logic            RS1_LINK,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] TARGET,
  output logic [XLEN-1:0] LINK,
  output logic            MISALIGNED,
  output logic            PRED_VALID,
  output logic [XLEN-1:0] PRED,
  output logic            MISPRED
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int AW = $clog2(ALIGN);

  logic            accept;
  logic [1:0]      ras_act;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;
  logic [CW-1:0]   ras_count;
  logic [XLEN-1:0] target_next;
  logic [XLEN-1:0] link_next;
  logic            misaligned_next;
  logic            pred_valid_next;
  logic [XLEN-1:0] pred_next;
  logic            mispred_next;

  assign IN_READY = !FLUSH && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;

  assign ras_act  = ras_action(OP, RD_LINK, RS1_LINK);
  assign ras_push = accept && (ras_act == RAS_ACT_PUSH || ras_act == RAS_ACT_REPLACE);
  assign ras_pop  = accept && (ras_act == RAS_ACT_POP || ras_act == RAS_ACT_REPLACE);

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk    (CLK),
    .resetn (RST_N),
    .push   (ras_push),
    .pop    (ras_pop),
    .data   (link_next),
    .top    (ras_top),
    .count  (ras_count)
  );

  // Target adders and op select; JALR clears bit 0 of its sum.
  always_comb begin
    target_next = PC;
    case (OP)
      JAL:     target_next = PC + J;
      BRANCH:  target_next = PC + B;
      JALR:    target_next = (RS1 + I) & ~XLEN'(1);
      default: target_next = PC;
    endcase
    link_next       = PC + XLEN'(4);
    misaligned_next = |target_next[AW-1:0];
    pred_valid_next = (ras_act == RAS_ACT_POP || ras_act == RAS_ACT_REPLACE) && ras_count != '0;
    pred_next       = pred_valid_next ? ras_top : '0;
    mispred_next    = pred_valid_next && (pred_next != target_next);
  end

  // Output register: loads on accept, flush only drops the valid flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_VALID  <= 1'b0;
      TARGET     <= '0;
      LINK       <= '0;
      MISALIGNED <= 1'b0;
      PRED_VALID <= 1'b0;
      PRED       <= '0;
      MISPRED    <= 1'b0;
    end else if (FLUSH) begin
      OUT_VALID <= 1'b0;
    end else if (accept) begin
      OUT_VALID  <= 1'b1;
      TARGET     <= target_next;
      LINK       <= link_next;
      MISALIGNED <= misaligned_next;
      PRED_VALID <= pred_valid_next;
      PRED       <= pred_next;
      MISPRED    <= mispred_next;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: doc/branch_target_unit.md
# branch_target_unit

Parametrised, registered successor to the OTTER branch address generator. It computes one JAL, BRANCH or JALR target per accepted request and registers the result behind a valid/ready handshake. A return-address stack (RAS) predicts JALR return targets and flags mispredictions. It sits between decode and the PC-select mux.

## Interface
- `XLEN`, 32: datapath width (≥ 8).
- `RAS_DEPTH`, 4: RAS entries (power of 2, ≥ 2).
- `ALIGN`, 4: required target alignment in bytes (2 or 4); sets MISALIGNED.

- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: synchronous reset, active-low.
- `FLUSH` in 1: drop the registered result.
- `IN_VALID` in 1: request present.
- `IN_READY` out 1: request accepted this cycle if IN_VALID.
- `OP` in 2: br_op_t (NONE, JAL, BRANCH, JALR).
- `PC`, `RS1`, `I`, `J`, `B` in XLEN: operands; immediates already sign-extended.
- `RD_LINK` in 1: rd ∈ {x1, x5}.
- `RS1_LINK` in 1: rs1 ∈ {x1, x5}.
- `OUT_VALID` out 1: result registered.
- `OUT_READY` in 1: consumer takes result.
- `TARGET` out XLEN: computed target.
- `LINK` out XLEN: PC+4.
- `MISALIGNED` out 1: TARGET not ALIGN-aligned.
- `PRED_VALID` out 1: RAS supplied a prediction for this result.
- `PRED` out XLEN: predicted target.
- `MISPRED` out 1: PRED_VALID && PRED != TARGET.

## Operation
- Accept = IN_VALID && IN_READY, where IN_READY = !FLUSH && (!OUT_VALID || OUT_READY).
- Targets use XLEN-bit modular adds; carry is discarded.
  - JAL = PC+J.
  - BRANCH = PC+B.
  - JALR = (RS1+I) with bit0 cleared.
  - NONE: TARGET = PC.
- LINK = PC+4, wrapping.
- MISALIGNED = TARGET[log2(ALIGN)-1:0] != 0. For ALIGN=4 this checks bits [1:0]; JALR bit0 is already 0.
- RAS actions apply only on accept.
  - Push LINK: JAL with RD_LINK; JALR with RD_LINK && !RS1_LINK.
  - Pop: JALR with RS1_LINK && !RD_LINK.
  - Pop-then-push (replace top): JALR with RD_LINK && RS1_LINK. Count is unchanged; if empty, this behaves as a push.
  - BRANCH and NONE leave the RAS untouched.
- Prediction: on a pop or replace with count > 0, register PRED = top-before-pop and PRED_VALID = 1. Otherwise PRED_VALID = 0 and PRED = 0.
- Full: a push when count == RAS_DEPTH overwrites the oldest entry (circular pointer) and count stays RAS_DEPTH.
- Empty: a pop with count == 0 leaves pointer and count unchanged and sets PRED_VALID = 0.
- FLUSH clears OUT_VALID next edge. The RAS is not rolled back, and no accept occurs that cycle.
- Output hold: while OUT_VALID && !OUT_READY, all outputs are stable.

## Timing
- Latency: 1 cycle, accept edge → OUT_VALID.
- Throughput: 1 per cycle while OUT_READY = 1.
- IN_READY is combinational from OUT_VALID, OUT_READY and FLUSH. There is no combinational path from IN_VALID to outputs.
- Reset (RST_N low at edge): OUT_VALID, PRED_VALID, MISPRED, MISALIGNED = 0; TARGET, LINK, PRED = 0; RAS count, pointer and entries = 0.
  - Reset overrides FLUSH and accept.
  - Reset mid-stream drops any held result.
- Registered outputs update only on accept, reset or flush. Flush changes OUT_VALID only.
- MISPRED is registered, computed from the same accepted inputs as TARGET.

## Structure
- `branch_pkg`:
  - `br_op_t` enum: NONE=2'b00, JAL=2'b01, BRANCH=2'b10, JALR=2'b11.
  - `RAS_ACT_*` constants (none/push/pop/replace).
- Sub-module `ras_stack`: circular LIFO parametrised by XLEN and RAS_DEPTH.
  - Inputs: push, pop, data.
  - Outputs: top, count.
  - Reset: synchronous, active-low.
- Top level holds the adders, op mux, output register and handshake.

## Test plan
- Reset, then JAL PC=0x100, J=0x20, RD_LINK → next cycle TARGET=0x120, LINK=0x104, OUT_VALID=1, MISALIGNED=0.
- JALR RS1=0x2001, I=0x4 → TARGET=0x2004. Same with I=0x1 → TARGET=0x2002, MISALIGNED=1 (ALIGN=4).
- Call at PC=0x100 (push 0x104), then ret JALR RS1=0x104, I=0, RS1_LINK → PRED=0x104, PRED_VALID=1, MISPRED=0. With RS1=0x108 → MISPRED=1.
- Five pushes (LINK 0x4..0x14) into RAS_DEPTH=4, then five pops → PRED 0x14, 0x10, 0xC, 0x8, then PRED_VALID=0 on the fifth.
- Hold OUT_READY=0 with IN_VALID=1 → IN_READY=0 and outputs stable. Release → one transfer per cycle. PC=0xFFFFFFFC → LINK=0x0.
- FLUSH while OUT_VALID=1 and IN_VALID=1 → OUT_VALID=0 next cycle, request not accepted. RST_N=0 mid-stream → all outputs and RAS cleared next edge.
